// File: rtl/bus_trace_ctrl.sv
// Bus trace controller: sequences the DUT reset, watches the processor bus,
// shadows writes into a small address window and stops the run on a halt
// write or a cycle timeout. The window is read back through a registered port.
module bus_trace_ctrl #(
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter int unsigned           ADDR_WIDTH      = 26,
  parameter logic [ADDR_WIDTH-1:0] WIN_BASE        = 26'h3fffff0,
  parameter int unsigned           WIN_DEPTH       = 16,
  parameter logic [ADDR_WIDTH-1:0] HALT_ADDR       = 26'h3ffffff,
  parameter int unsigned           RST_HOLD_CYCLES = 2,
  parameter int unsigned           TIMEOUT_CYCLES  = 1000,
  parameter int unsigned           CNT_WIDTH       = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         START,
  input  logic [ADDR_WIDTH-1:0]        ADDR,
  input  logic [DATA_WIDTH-1:0]        DATA,
  input  logic                         READ,
  input  logic                         WRITE,
  output logic                         DUT_RST,
  output logic                         BUSY,
  output logic                         DONE,
  output logic                         TIMEOUT,
  output logic                         BUS_ERR,
  output logic [CNT_WIDTH-1:0]         CYCLE_COUNT,
  output logic [CNT_WIDTH-1:0]         WR_COUNT,
  output logic [CNT_WIDTH-1:0]         RD_COUNT,
  input  logic [$clog2(WIN_DEPTH)-1:0] RD_IDX,
  output logic [DATA_WIDTH-1:0]        RD_DATA,
  output logic                         RD_VALID
);

  localparam int unsigned IDX_W  = $clog2(WIN_DEPTH);
  // Hold counter runs 0 .. RST_HOLD_CYCLES-1 (RST_HOLD_CYCLES must be >= 1).
  localparam int unsigned HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RESET_DUT = 2'd1,
    S_RUN       = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t                  state_q;
  logic                    dut_rst_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    timeout_q;
  logic                    bus_err_q;
  logic [HOLD_W-1:0]       hold_q;
  logic [CNT_WIDTH-1:0]    cycle_q;
  logic [CNT_WIDTH-1:0]    wr_cnt_q;
  logic [CNT_WIDTH-1:0]    rd_cnt_q;
  logic                    prev_wr_q;
  logic                    prev_rd_q;
  logic [WIN_DEPTH-1:0]    valid_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic                    rd_valid_q;
  logic [DATA_WIDTH-1:0]   shadow_mem [WIN_DEPTH];

  logic                    start_go;
  logic                    wr_edge;
  logic                    rd_edge;
  logic                    both_strobes;
  logic [ADDR_WIDTH-1:0]   offset;
  logic                    in_win;
  logic [IDX_W-1:0]        cap_idx;
  logic                    capture;
  logic                    halt;
  logic [CNT_WIDTH-1:0]    cycle_d;
  logic                    tmo;

  // Saturating increment so counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Decode bus events for the current cycle; only acted upon while in RUN.
  always_comb begin
    start_go     = START && ((state_q == S_IDLE) || (state_q == S_DONE));
    wr_edge      = WRITE && !prev_wr_q;
    rd_edge      = READ && !prev_rd_q;
    both_strobes = READ && WRITE;
    // Offset test avoids computing WIN_BASE+WIN_DEPTH, which can overflow the address width.
    offset       = ADDR - WIN_BASE;
    in_win       = (ADDR >= WIN_BASE) && (offset < ADDR_WIDTH'(WIN_DEPTH));
    cap_idx      = offset[IDX_W-1:0];
    capture      = (state_q == S_RUN) && WRITE && !READ && in_win;
    halt         = wr_edge && !READ && (ADDR == HALT_ADDR);
    cycle_d      = sat_inc(cycle_q);
    tmo          = (cycle_d == CNT_WIDTH'(TIMEOUT_CYCLES));
  end

  // Run sequencer with registered status outputs and run counters.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      dut_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      bus_err_q <= 1'b0;
      hold_q    <= '0;
      cycle_q   <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      prev_wr_q <= 1'b0;
      prev_rd_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (START) begin
            state_q   <= S_RESET_DUT;
            dut_rst_q <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            bus_err_q <= 1'b0;
            hold_q    <= '0;
            cycle_q   <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
          end
        end
        S_RESET_DUT: begin
          if (hold_q == HOLD_LAST) begin
            state_q   <= S_RUN;
            dut_rst_q <= 1'b1;
            // Cleared so a strobe already high in the first RUN cycle is an edge.
            prev_wr_q <= 1'b0;
            prev_rd_q <= 1'b0;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        S_RUN: begin
          cycle_q   <= cycle_d;
          prev_wr_q <= WRITE;
          prev_rd_q <= READ;
          if (both_strobes) begin
            bus_err_q <= 1'b1;
          end else begin
            if (wr_edge) wr_cnt_q <= sat_inc(wr_cnt_q);
            if (rd_edge) rd_cnt_q <= sat_inc(rd_cnt_q);
          end
          // Halt takes priority over a timeout landing on the same cycle.
          if (halt || tmo) begin
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= !halt;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Per-entry valid flags: cleared when a run starts, set by a capture.
  for (genvar gi = 0; gi < WIN_DEPTH; gi++) begin : g_valid
    logic bit_q;
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        bit_q <= 1'b0;
      end else if (start_go) begin
        bit_q <= 1'b0;
      end else if (capture && (cap_idx == IDX_W'(gi))) begin
        bit_q <= 1'b1;
      end
    end
    assign valid_q[gi] = bit_q;
  end

  // Shadow storage write port; contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (capture) begin
      shadow_mem[cap_idx] <= DATA;
    end
  end

  // Registered readback; a same-cycle capture shows up one cycle later.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= shadow_mem[RD_IDX];
      rd_valid_q <= valid_q[RD_IDX];
    end
  end

  assign DUT_RST     = dut_rst_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign TIMEOUT     = timeout_q;
  assign BUS_ERR     = bus_err_q;
  assign CYCLE_COUNT = cycle_q;
  assign WR_COUNT    = wr_cnt_q;
  assign RD_COUNT    = rd_cnt_q;
  assign RD_DATA     = rd_data_q;
  assign RD_VALID    = rd_valid_q;

endmodule

// File: tb/tb_bus_trace_ctrl.sv
// Testbench for bus_trace_ctrl: random and directed bus runs, a behavioural
// model of the window/counters, and a monitor popping expected readbacks and
// end-of-run status from queues.
module tb_bus_trace_ctrl;

  localparam int DEPTH = 16;
  localparam int HOLD  = 2;
  localparam int TMO   = 1000;
  localparam logic [25:0] BASE  = 26'h3fffff0;
  localparam logic [25:0] HALTA = 26'h3ffffff;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [25:0] ADDR = '0;
  logic [31:0] DATA = '0;
  logic        READ = 1'b0;
  logic        WRITE = 1'b0;
  logic [3:0]  RD_IDX = '0;
  logic        DUT_RST, BUSY, DONE, TIMEOUT, BUS_ERR, RD_VALID;
  logic [31:0] CYCLE_COUNT, WR_COUNT, RD_COUNT, RD_DATA;

  bus_trace_ctrl dut (
    .CLK(CLK), .RST(RST), .START(START), .ADDR(ADDR), .DATA(DATA),
    .READ(READ), .WRITE(WRITE), .DUT_RST(DUT_RST), .BUSY(BUSY), .DONE(DONE),
    .TIMEOUT(TIMEOUT), .BUS_ERR(BUS_ERR), .CYCLE_COUNT(CYCLE_COUNT),
    .WR_COUNT(WR_COUNT), .RD_COUNT(RD_COUNT), .RD_IDX(RD_IDX),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass = 0;

  function automatic void chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endfunction

  function automatic void fail_note(input string nm);
    n_checks++;
    $display("FAIL %s: event not seen as expected", nm);
  endfunction

  // Behavioural model of the shadow window and run status.
  logic [31:0] m_data [DEPTH];
  bit          m_valid [DEPTH];
  bit          m_known [DEPTH];
  longint      m_cyc, m_wr, m_rd;
  bit          m_err, m_pwr, m_prd;

  typedef struct { logic [31:0] data; bit valid; bit known; } rd_exp_t;
  typedef struct { bit tmo; bit err; longint cyc; longint wr; longint rd; } st_exp_t;
  rd_exp_t rd_q[$];
  st_exp_t st_q[$];
  logic rd_req = 1'b0;

  function automatic void push_rd(input int idx);
    rd_exp_t e;
    e.data  = m_data[idx];
    e.valid = m_valid[idx];
    e.known = m_known[idx];
    rd_q.push_back(e);
  endfunction

  // One RUN cycle of the model; returns 1 when the run ends on this cycle.
  function automatic bit model_step(input int n, input logic [25:0] a, input logic [31:0] d,
                                    input bit r, input bit w);
    bit halt, tmo;
    longint off;
    st_exp_t s;
    m_cyc = n;
    halt = w && !r && !m_pwr && (a == HALTA);
    if (r && w) begin
      m_err = 1;
    end else begin
      if (w && !m_pwr) m_wr++;
      if (r && !m_prd) m_rd++;
      off = longint'(a) - longint'(BASE);
      if (w && off >= 0 && off < DEPTH) begin
        m_data[off] = d;
        m_valid[off] = 1;
        m_known[off] = 1;
      end
    end
    m_pwr = w;
    m_prd = r;
    tmo = (n == TMO);
    if (halt || tmo) begin
      s.tmo = tmo && !halt;
      s.err = m_err;
      s.cyc = m_cyc;
      s.wr  = m_wr;
      s.rd  = m_rd;
      st_q.push_back(s);
      return 1;
    end
    return 0;
  endfunction

  // Bus pattern for RUN cycle n of a given scenario.
  function automatic void gen(input int mode, input int n, input int halt_at,
                              output logic [25:0] a, output logic [31:0] d,
                              output bit r, output bit w, output bit rdo);
    int k;
    a = 26'($urandom);
    d = $urandom;
    r = 0;
    w = 0;
    rdo = ($urandom % 2) == 1;
    case (mode)
      0: begin
        if (n == 1) begin w = 1; a = BASE + 26'd3; d = 32'hA5; end
        else if (n == 3) begin w = 1; a = BASE + 26'd3; d = 32'h5A; end
        else if (n == 5) begin w = 1; a = 26'h3ffffef; end
      end
      1: begin
        if (n == 1) begin w = 1; a = BASE + 26'd3; d = 32'hA5; end
        else if (n == 2) begin w = 1; a = BASE + 26'd3; d = 32'h5A; end
        else if (n == 4) begin w = 1; a = 26'h3ffffef; end
      end
      2, 3: r = ($urandom % 3) == 0;
      4: begin
        if (n == 3) begin w = 1; a = BASE + 26'd2; end
        else if (n == 6) begin w = 1; r = 1; a = BASE + 26'd7; end
      end
      default: begin
        k = $urandom % 10;
        if (k == 4 || k == 5) r = 1;
        else if (k >= 6) begin
          w = 1;
          a = (k == 9) ? BASE - 26'(1 + $urandom % 8) : BASE + 26'($urandom % 15);
        end
        if (mode == 5 && n == 1) begin w = 1; r = 0; a = BASE + 26'd4; end
        if (n == halt_at - 1) w = 0;
        if (mode == 6 && n == 20) begin r = 0; w = 0; rdo = 0; end
      end
    endcase
    if (n == halt_at) begin w = 1; r = 0; a = HALTA; end
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic readback(input int idx);
    RD_IDX = 4'(idx);
    push_rd(idx);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  // Monitor: compares readbacks one cycle after issue and status when DONE rises.
  initial begin : monitor
    bit rq;
    bit dprev;
    rd_exp_t e;
    st_exp_t s;
    dprev = 0;
    forever begin
      @(posedge CLK);
      rq = rd_req;
      #2;
      if (rq) begin
        if (rd_q.size() == 0) fail_note("rd_unexpected");
        else begin
          e = rd_q.pop_front();
          chk("rd_valid", RD_VALID, e.valid);
          if (e.known) chk("rd_data", RD_DATA, e.data);
        end
      end
      if (DONE && !dprev) begin
        if (st_q.size() == 0) fail_note("done_unexpected");
        else begin
          s = st_q.pop_front();
          $display("run end: timeout=%0d bus_err=%0d cycles=%0d wr=%0d rd=%0d", TIMEOUT, BUS_ERR,
                   CYCLE_COUNT, WR_COUNT, RD_COUNT);
          chk("done_timeout", TIMEOUT, s.tmo);
          chk("done_bus_err", BUS_ERR, s.err);
          chk("done_cycles", CYCLE_COUNT, s.cyc);
          chk("done_wr", WR_COUNT, s.wr);
          chk("done_rd", RD_COUNT, s.rd);
          chk("done_busy", BUSY, 0);
          chk("done_dut_rst", DUT_RST, 1);
        end
      end
      dprev = DONE;
    end
  end

  task automatic do_run(input int mode, input int halt_at);
    logic [25:0] a;
    logic [31:0] d;
    bit r, w, rdo, ended, aborted, pre_w;
    int idx;
    pre_w = (mode == 5);
    ADDR = pre_w ? BASE + 26'd4 : '0;
    DATA = 32'h1234;
    WRITE = pre_w;
    READ = 0;
    rd_req = 0;
    START = 1;
    tick();
    START = 0;
    m_cyc = 0; m_wr = 0; m_rd = 0; m_err = 0; m_pwr = 0; m_prd = 0;
    foreach (m_valid[i]) m_valid[i] = 0;
    chk("start_cyc", CYCLE_COUNT, 0);
    chk("start_wr", WR_COUNT, 0);
    chk("start_rd", RD_COUNT, 0);
    chk("start_bus_err", BUS_ERR, 0);
    chk("start_timeout", TIMEOUT, 0);
    chk("start_done", DONE, 0);
    for (int h = 0; h < HOLD; h++) begin
      chk("hold_dut_rst", DUT_RST, 0);
      chk("hold_busy", BUSY, 1);
      START = (h == 0);
      tick();
      START = 0;
    end
    ended = 0;
    aborted = 0;
    for (int n = 1; n <= TMO + 2 && !ended; n++) begin
      chk("run_dut_rst", DUT_RST, 1);
      chk("run_busy", BUSY, 1);
      chk("run_cyc", CYCLE_COUNT, n - 1);
      chk("run_wr", WR_COUNT, m_wr);
      chk("run_rd", RD_COUNT, m_rd);
      chk("run_bus_err", BUS_ERR, m_err);
      gen(mode, n, halt_at, a, d, r, w, rdo);
      ADDR = a; DATA = d; READ = r; WRITE = w;
      if (rdo) begin
        idx = $urandom % DEPTH;
        RD_IDX = 4'(idx);
        push_rd(idx);
        rd_req = 1;
      end else begin
        rd_req = 0;
      end
      ended = model_step(n, a, d, r, w);
      tick();
      if (mode == 6 && n == 20) begin
        aborted = 1;
        break;
      end
    end
    rd_req = 0;
    READ = 0;
    WRITE = 0;
    if (aborted) begin
      RST = 0;
      #1;
      $display("mid-run reset: dut_rst=%0d busy=%0d cycles=%0d", DUT_RST, BUSY, CYCLE_COUNT);
      chk("mr_dut_rst", DUT_RST, 0);
      chk("mr_busy", BUSY, 0);
      chk("mr_done", DONE, 0);
      chk("mr_cyc", CYCLE_COUNT, 0);
      chk("mr_wr", WR_COUNT, 0);
      chk("mr_rd", RD_COUNT, 0);
      chk("mr_rd_valid", RD_VALID, 0);
      chk("mr_rd_data", RD_DATA, 0);
      foreach (m_valid[i]) m_valid[i] = 0;
      tick();
      tick();
      @(negedge CLK);
      RST = 1;
      tick();
      chk("mr_idle_dut_rst", DUT_RST, 0);
      chk("mr_idle_busy", BUSY, 0);
    end else begin
      for (int k = 0; k < 5 && st_q.size() != 0; k++) tick();
      if (st_q.size() != 0) begin
        fail_note("done_never_reached");
        st_q.delete();
      end
    end
  endtask

  // After DONE: bus activity must not move counters or capture; then sweep the window.
  task automatic post_run();
    for (int k = 0; k < 4; k++) begin
      ADDR = BASE + 26'd1;
      DATA = $urandom;
      WRITE = (k % 2) == 0;
      READ = 0;
      tick();
      chk("frozen_cyc", CYCLE_COUNT, m_cyc);
      chk("frozen_wr", WR_COUNT, m_wr);
      chk("frozen_done", DONE, 1);
    end
    WRITE = 0;
    for (int i = 0; i < DEPTH; i++) readback(i);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    foreach (m_known[i]) begin
      m_known[i] = 0;
      m_valid[i] = 0;
      m_data[i] = '0;
    end
    #2;
    RST = 0;
    #1;
    chk("rst_dut_rst", DUT_RST, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_timeout", TIMEOUT, 0);
    chk("rst_bus_err", BUS_ERR, 0);
    chk("rst_cyc", CYCLE_COUNT, 0);
    chk("rst_wr", WR_COUNT, 0);
    chk("rst_rd", RD_COUNT, 0);
    chk("rst_rd_valid", RD_VALID, 0);
    chk("rst_rd_data", RD_DATA, 0);
    @(negedge CLK);
    RST = 1;
    tick();
    tick();
    chk("idle_dut_rst", DUT_RST, 0);
    chk("idle_busy", BUSY, 0);

    do_run(0, 40);   post_run();
    do_run(1, 40);   post_run();
    do_run(4, 50);   post_run();
    do_run(2, 0);    post_run();
    do_run(3, TMO);  post_run();
    repeat (5) begin
      do_run(5, int'($urandom_range(30, 300)));
      post_run();
    end
    do_run(6, 0);
    for (int i = 0; i < DEPTH; i++) readback(i);
    do_run(5, 60);   post_run();

    tick();
    if (rd_q.size() != 0) fail_note("rd_left_pending");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_trace_ctrl.md
Name: bus_trace_ctrl

Overview:
Synthesizable simulation controller for DA_VINCI-class processors. It sequences the DUT reset and observes the processor memory bus (ADDR/DATA/READ/WRITE). It shadows writes that fall into a configurable address window and ends the run on a write to a halt address or on a cycle timeout. The bench instantiates it beside the DUT and reads the window back through a registered readback port instead of poking memory hierarchy by name.

Parameters:
DATA_WIDTH, 32, bus data width
ADDR_WIDTH, 26, bus address width
WIN_BASE, 26'h3fffff0, first address of the shadow window
WIN_DEPTH, 16, shadow entries; power of two, >= 2
HALT_ADDR, 26'h3ffffff, write to this address ends the run
RST_HOLD_CYCLES, 2, cycles DUT_RST is held low after START
TIMEOUT_CYCLES, 1000, RUN cycles before forced stop
CNT_WIDTH, 32, width of all counters

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  asynchronous, active-low reset
START  input  1  one-cycle pulse; begins a run
ADDR  input  ADDR_WIDTH  observed bus address
DATA  input  DATA_WIDTH  observed bus data
READ  input  1  observed read strobe
WRITE  input  1  observed write strobe
DUT_RST  output  1  active-low reset to DUT
BUSY  output  1  high in RESET_DUT or RUN
DONE  output  1  high in DONE state
TIMEOUT  output  1  run ended by timeout
BUS_ERR  output  1  sticky; READ and WRITE were seen high together
CYCLE_COUNT  output  CNT_WIDTH  RUN cycles elapsed
WR_COUNT  output  CNT_WIDTH  write transactions seen
RD_COUNT  output  CNT_WIDTH  read transactions seen
RD_IDX  input  log2(WIN_DEPTH)  shadow readback index
RD_DATA  output  DATA_WIDTH  shadow[RD_IDX], registered
RD_VALID  output  1  entry RD_IDX written this run, registered

Behaviour:
- RST low (async): state=IDLE; DUT_RST=0; BUSY, DONE, TIMEOUT, BUS_ERR=0; all counters=0; all valid bits=0; RD_DATA=0; RD_VALID=0. Shadow data contents are not reset.
- States are IDLE, RESET_DUT, RUN, DONE.
- IDLE: DUT_RST=0. If START=1, go to RESET_DUT. This clears counters, valid bits, TIMEOUT, BUS_ERR and the hold counter.
- RESET_DUT: DUT_RST=0 for exactly RST_HOLD_CYCLES cycles, then go to RUN. DUT_RST=1 from the first RUN cycle. START is ignored.
- RUN:
  - CYCLE_COUNT increments every cycle.
  - A transaction is the 0->1 edge of its strobe. The previous strobe value is registered and cleared on entry to RUN, so a strobe already high in the first RUN cycle counts.
  - A WRITE edge increments WR_COUNT; a READ edge increments RD_COUNT.
  - READ=1 and WRITE=1 in the same cycle sets BUS_ERR. Neither counter increments, and no capture happens that cycle.
  - Capture: on every cycle with WRITE=1, READ=0 and WIN_BASE <= ADDR < WIN_BASE+WIN_DEPTH, shadow[ADDR-WIN_BASE] <= DATA and its valid bit is set. Last write wins. The subtraction is ADDR_WIDTH wide and uses the low log2(WIN_DEPTH) bits.
  - START is ignored.
- RUN exit, evaluated every cycle after that cycle's updates:
  - halt = WRITE edge with ADDR==HALT_ADDR.
  - timeout = CYCLE_COUNT reaching TIMEOUT_CYCLES, i.e. the cycle in which the count becomes TIMEOUT_CYCLES.
  - Either condition moves to DONE. If both occur in the same cycle, halt wins and TIMEOUT=0.
  - A halt address inside the window is also captured.
- DONE: DONE=1, DUT_RST stays 1, capture and all counters frozen, outputs hold. START=1 goes to RESET_DUT as a restart with counters and valid bits cleared.
- Counters saturate at all-ones and never wrap.
- Readback: RD_DATA and RD_VALID reflect RD_IDX sampled one cycle earlier, in any state. If a capture and a read hit the same entry in one cycle, the old value is returned; the new value appears the following cycle.
- Async reset mid-run returns to IDLE immediately; DUT_RST falls asynchronously.

Test Plan:
- Reset and hold: RST low, then release; START pulse at cycle 3 -> DUT_RST=0 through cycle 5 with RST_HOLD_CYCLES=2. DUT_RST=1 and BUSY=1 from cycle 6; CYCLE_COUNT=1 after the first RUN edge.
- Window capture: write 32'hA5 to 26'h3fffff3, then 32'h5A to the same address, then a write to 26'h3ffffef -> RD_IDX=3 gives RD_DATA=32'h5A and RD_VALID=1. RD_IDX=0 gives RD_VALID=0. WR_COUNT=3 if the strobe dropped between writes, 2 if it stayed high across the two same-address writes.
- Halt: WRITE edge to 26'h3ffffff at RUN cycle 40 -> DONE=1, TIMEOUT=0, CYCLE_COUNT=40 and frozen. A later write to window entry 1 leaves its RD_VALID=0.
- Timeout versus simultaneous halt: with TIMEOUT_CYCLES=1000 and no halt, DONE=1, TIMEOUT=1 and CYCLE_COUNT=1000. With a halt edge exactly on cycle 1000, TIMEOUT=0.
- Bus error: READ=WRITE=1 for one cycle inside the window -> BUS_ERR=1 and sticky; no counter change; no capture.
- Mid-run reset and restart: RST low at RUN cycle 20 -> immediate IDLE, DUT_RST=0, counters=0. A later START after DONE clears all valid bits and BUS_ERR and repeats the reset sequence.
